// File: rtl/rob_commit_unit.sv
// -----------------------------------------------------------------------------
// rob_commit_unit
//
// 2-wide in-order reorder buffer.
//   - Accepts up to two renamed instructions per cycle from rename (slot 1 is
//     younger than slot 0) and hands back the ROB ids they were given.
//   - Records completion from three writeback ports (done, plus a sticky
//     "flush at retirement" marker).
//   - Retires up to two completed instructions per cycle in program order and
//     presents their rename info for the free list / map table.
//   - Retiring a flush-marked instruction empties the whole ROB and pulses
//     recover for one cycle.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   disp_valid_0/1                 dispatch slot valid (slot 1 younger)
//   disp_wen/ard/prd_new/prd_stale dispatch payload per slot
//   disp_ready                     two entries free and not recovering
//   disp_id_0/1                    ROB id given to each slot (from tail)
//   wb_valid/id/flush_0..2         writeback completion ports
//   commit_valid_0/1               retirement slot valid (registered)
//   commit_wen/ard/prd_new/stale   retired entry payload (zero when idle)
//   recover                        one-cycle flush pulse (registered)
//   rob_empty                      no entries in flight
// -----------------------------------------------------------------------------
module rob_commit_unit #(
   parameter int DEPTH = 32,
   parameter int ID_W  = 5,
   parameter int ARF_W = 5,
   parameter int PRF_W = 6
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             disp_valid_0,
   input  logic             disp_valid_1,
   input  logic             disp_wen_0,
   input  logic             disp_wen_1,
   input  logic [ARF_W-1:0] disp_ard_0,
   input  logic [ARF_W-1:0] disp_ard_1,
   input  logic [PRF_W-1:0] disp_prd_new_0,
   input  logic [PRF_W-1:0] disp_prd_new_1,
   input  logic [PRF_W-1:0] disp_prd_stale_0,
   input  logic [PRF_W-1:0] disp_prd_stale_1,
   output logic             disp_ready,
   output logic [ID_W-1:0]  disp_id_0,
   output logic [ID_W-1:0]  disp_id_1,

   input  logic             wb_valid_0,
   input  logic             wb_valid_1,
   input  logic             wb_valid_2,
   input  logic [ID_W-1:0]  wb_id_0,
   input  logic [ID_W-1:0]  wb_id_1,
   input  logic [ID_W-1:0]  wb_id_2,
   input  logic             wb_flush_0,
   input  logic             wb_flush_1,
   input  logic             wb_flush_2,

   output logic             commit_valid_0,
   output logic             commit_valid_1,
   output logic             commit_wen_0,
   output logic             commit_wen_1,
   output logic [ARF_W-1:0] commit_ard_0,
   output logic [ARF_W-1:0] commit_ard_1,
   output logic [PRF_W-1:0] commit_prd_new_0,
   output logic [PRF_W-1:0] commit_prd_new_1,
   output logic [PRF_W-1:0] commit_prd_stale_0,
   output logic [PRF_W-1:0] commit_prd_stale_1,
   output logic             recover,
   output logic             rob_empty
);

   localparam int NWB = 3;
   // Highest occupancy at which a full two-wide dispatch still fits.
   localparam logic [ID_W:0] READY_MAX = (ID_W+1)'(DEPTH - 2);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] done_q,  done_d;
   logic [DEPTH-1:0] flush_q, flush_d;

   // Payload: only meaningful while the matching valid bit is set.
   logic [DEPTH-1:0] wen_q;
   logic [ARF_W-1:0] ard_q       [DEPTH];
   logic [PRF_W-1:0] prd_new_q   [DEPTH];
   logic [PRF_W-1:0] prd_stale_q [DEPTH];

   logic [ID_W-1:0]  head_q,  head_d;
   logic [ID_W-1:0]  tail_q,  tail_d;
   logic [ID_W:0]    count_q, count_d;
   logic             recover_q;

   logic             commit_valid_0_q, commit_valid_1_q;
   logic             commit_wen_0_q,   commit_wen_1_q;
   logic [ARF_W-1:0] commit_ard_0_q,   commit_ard_1_q;
   logic [PRF_W-1:0] commit_new_0_q,   commit_new_1_q;
   logic [PRF_W-1:0] commit_stale_0_q, commit_stale_1_q;

   // ---------------------------------------------------------------------------
   // Writeback ports gathered into arrays so they can be walked in a loop
   // ---------------------------------------------------------------------------
   logic [NWB-1:0]  wb_valid;
   logic [NWB-1:0]  wb_flush;
   logic [ID_W-1:0] wb_id [NWB];

   assign wb_valid = {wb_valid_2, wb_valid_1, wb_valid_0};
   assign wb_flush = {wb_flush_2, wb_flush_1, wb_flush_0};
   assign wb_id[0] = wb_id_0;
   assign wb_id[1] = wb_id_1;
   assign wb_id[2] = wb_id_2;

   // ---------------------------------------------------------------------------
   // Dispatch / commit decisions
   // ---------------------------------------------------------------------------
   logic [ID_W-1:0] head_p1;
   logic [ID_W-1:0] slot1_id;
   logic            ready;
   logic            disp_fire_0, disp_fire_1;
   logic            commit_0, commit_1, flush_commit;
   logic [ID_W:0]   n_disp, n_commit;

   assign head_p1  = head_q + ID_W'(1);
   // Slot 1 packs down onto tail when slot 0 is empty.
   assign slot1_id = disp_valid_0 ? tail_q + ID_W'(1) : tail_q;

   assign ready       = (count_q <= READY_MAX) && !recover_q;
   assign disp_fire_0 = ready && disp_valid_0;
   assign disp_fire_1 = ready && disp_valid_1;

   // Commit reads only registered done bits, so a writeback becomes
   // retireable one cycle later.  Nothing retires in the recover cycle.
   assign commit_0     = !recover_q && valid_q[head_q] && done_q[head_q];
   // A flushing instruction retires alone: anything younger is squashed.
   assign commit_1     = commit_0 && !flush_q[head_q]
                         && valid_q[head_p1] && done_q[head_p1];
   assign flush_commit = commit_0 && flush_q[head_q];

   assign n_disp   = {{ID_W{1'b0}}, disp_fire_0} + {{ID_W{1'b0}}, disp_fire_1};
   assign n_commit = {{ID_W{1'b0}}, commit_0}    + {{ID_W{1'b0}}, commit_1};

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any conditional update, so
      // no path leaves it unassigned and no latch is inferred.
      valid_d = valid_q;
      done_d  = done_q;
      flush_d = flush_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      // Writeback: only live entries are marked.  Several ports hitting the
      // same id simply OR their done/flush contributions.
      for (int p = 0; p < NWB; p++) begin
         if (wb_valid[p] && valid_q[wb_id[p]]) begin
            done_d[wb_id[p]] = 1'b1;
            if (wb_flush[p]) begin
               flush_d[wb_id[p]] = 1'b1;
            end
         end
      end

      // Retirement frees entries at head.
      if (commit_0) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
         flush_d[head_q] = 1'b0;
      end
      if (commit_1) begin
         valid_d[head_p1] = 1'b0;
         done_d[head_p1]  = 1'b0;
         flush_d[head_p1] = 1'b0;
      end

      // Dispatch claims free entries at tail; these never alias a live entry
      // because ready guarantees two free slots.
      if (disp_fire_0) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
         flush_d[tail_q] = 1'b0;
      end
      if (disp_fire_1) begin
         valid_d[slot1_id] = 1'b1;
         done_d[slot1_id]  = 1'b0;
         flush_d[slot1_id] = 1'b0;
      end

      head_d  = head_q + n_commit[ID_W-1:0];
      tail_d  = tail_q + n_disp[ID_W-1:0];
      count_d = count_q + n_disp - n_commit;

      // Flush retirement wipes everything, including this cycle's dispatch.
      if (flush_commit) begin
         valid_d = '0;
         done_d  = '0;
         flush_d = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Control state and commit output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         valid_q          <= '0;
         done_q           <= '0;
         flush_q          <= '0;
         head_q           <= '0;
         tail_q           <= '0;
         count_q          <= '0;
         recover_q        <= 1'b0;
         commit_valid_0_q <= 1'b0;
         commit_valid_1_q <= 1'b0;
         commit_wen_0_q   <= 1'b0;
         commit_wen_1_q   <= 1'b0;
         commit_ard_0_q   <= '0;
         commit_ard_1_q   <= '0;
         commit_new_0_q   <= '0;
         commit_new_1_q   <= '0;
         commit_stale_0_q <= '0;
         commit_stale_1_q <= '0;
      end else begin
         valid_q          <= valid_d;
         done_q           <= done_d;
         flush_q          <= flush_d;
         head_q           <= head_d;
         tail_q           <= tail_d;
         count_q          <= count_d;
         recover_q        <= flush_commit;
         commit_valid_0_q <= commit_0;
         commit_valid_1_q <= commit_1;
         commit_wen_0_q   <= commit_0 && wen_q[head_q];
         commit_wen_1_q   <= commit_1 && wen_q[head_p1];
         commit_ard_0_q   <= commit_0 ? ard_q[head_q]        : '0;
         commit_ard_1_q   <= commit_1 ? ard_q[head_p1]       : '0;
         commit_new_0_q   <= commit_0 ? prd_new_q[head_q]    : '0;
         commit_new_1_q   <= commit_1 ? prd_new_q[head_p1]   : '0;
         commit_stale_0_q <= commit_0 ? prd_stale_q[head_q]  : '0;
         commit_stale_1_q <= commit_1 ? prd_stale_q[head_p1] : '0;
      end
   end

   // NOTE: the payload array has no reset; valid_q gates every use of it, so
   // clearing it would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (disp_fire_0) begin
         wen_q[tail_q]       <= disp_wen_0;
         ard_q[tail_q]       <= disp_ard_0;
         prd_new_q[tail_q]   <= disp_prd_new_0;
         prd_stale_q[tail_q] <= disp_prd_stale_0;
      end
      if (disp_fire_1) begin
         wen_q[slot1_id]       <= disp_wen_1;
         ard_q[slot1_id]       <= disp_ard_1;
         prd_new_q[slot1_id]   <= disp_prd_new_1;
         prd_stale_q[slot1_id] <= disp_prd_stale_1;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign disp_ready         = ready;
   assign disp_id_0          = tail_q;
   assign disp_id_1          = slot1_id;
   assign commit_valid_0     = commit_valid_0_q;
   assign commit_valid_1     = commit_valid_1_q;
   assign commit_wen_0       = commit_wen_0_q;
   assign commit_wen_1       = commit_wen_1_q;
   assign commit_ard_0       = commit_ard_0_q;
   assign commit_ard_1       = commit_ard_1_q;
   assign commit_prd_new_0   = commit_new_0_q;
   assign commit_prd_new_1   = commit_new_1_q;
   assign commit_prd_stale_0 = commit_stale_0_q;
   assign commit_prd_stale_1 = commit_stale_1_q;
   assign recover            = recover_q;
   assign rob_empty          = (count_q == '0);

endmodule

// File: tb/tb_rob_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_rob_commit_unit
//
// Directed stimulus drives dispatch/writeback; every accepted instruction that
// is expected to retire is pushed into exp_q in program order.  A monitor
// samples the commit ports on the falling edge and pops/compares in order.
// -----------------------------------------------------------------------------
module tb_rob_commit_unit;

   localparam int DEPTH = 32;
   localparam int ID_W  = 5;
   localparam int ARF_W = 5;
   localparam int PRF_W = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             disp_valid_0 = 1'b0, disp_valid_1 = 1'b0;
   logic             disp_wen_0 = 1'b0, disp_wen_1 = 1'b0;
   logic [ARF_W-1:0] disp_ard_0 = '0, disp_ard_1 = '0;
   logic [PRF_W-1:0] disp_prd_new_0 = '0, disp_prd_new_1 = '0;
   logic [PRF_W-1:0] disp_prd_stale_0 = '0, disp_prd_stale_1 = '0;
   logic             disp_ready;
   logic [ID_W-1:0]  disp_id_0, disp_id_1;
   logic             wb_valid_0 = 1'b0, wb_valid_1 = 1'b0, wb_valid_2 = 1'b0;
   logic [ID_W-1:0]  wb_id_0 = '0, wb_id_1 = '0, wb_id_2 = '0;
   logic             wb_flush_0 = 1'b0, wb_flush_1 = 1'b0, wb_flush_2 = 1'b0;
   logic             commit_valid_0, commit_valid_1;
   logic             commit_wen_0, commit_wen_1;
   logic [ARF_W-1:0] commit_ard_0, commit_ard_1;
   logic [PRF_W-1:0] commit_prd_new_0, commit_prd_new_1;
   logic [PRF_W-1:0] commit_prd_stale_0, commit_prd_stale_1;
   logic             recover, rob_empty;

   rob_commit_unit #(
      .DEPTH(DEPTH), .ID_W(ID_W), .ARF_W(ARF_W), .PRF_W(PRF_W)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .disp_valid_0       (disp_valid_0),
      .disp_valid_1       (disp_valid_1),
      .disp_wen_0         (disp_wen_0),
      .disp_wen_1         (disp_wen_1),
      .disp_ard_0         (disp_ard_0),
      .disp_ard_1         (disp_ard_1),
      .disp_prd_new_0     (disp_prd_new_0),
      .disp_prd_new_1     (disp_prd_new_1),
      .disp_prd_stale_0   (disp_prd_stale_0),
      .disp_prd_stale_1   (disp_prd_stale_1),
      .disp_ready         (disp_ready),
      .disp_id_0          (disp_id_0),
      .disp_id_1          (disp_id_1),
      .wb_valid_0         (wb_valid_0),
      .wb_valid_1         (wb_valid_1),
      .wb_valid_2         (wb_valid_2),
      .wb_id_0            (wb_id_0),
      .wb_id_1            (wb_id_1),
      .wb_id_2            (wb_id_2),
      .wb_flush_0         (wb_flush_0),
      .wb_flush_1         (wb_flush_1),
      .wb_flush_2         (wb_flush_2),
      .commit_valid_0     (commit_valid_0),
      .commit_valid_1     (commit_valid_1),
      .commit_wen_0       (commit_wen_0),
      .commit_wen_1       (commit_wen_1),
      .commit_ard_0       (commit_ard_0),
      .commit_ard_1       (commit_ard_1),
      .commit_prd_new_0   (commit_prd_new_0),
      .commit_prd_new_1   (commit_prd_new_1),
      .commit_prd_stale_0 (commit_prd_stale_0),
      .commit_prd_stale_1 (commit_prd_stale_1),
      .recover            (recover),
      .rob_empty          (rob_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             wen;
      logic [ARF_W-1:0] ard;
      logic [PRF_W-1:0] pnew;
      logic [PRF_W-1:0] pstale;
      logic             flush;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int tag, input bit fl);
      exp_t e;
      e.wen    = (tag % 3) != 0;
      e.ard    = ARF_W'(tag % 32);
      e.pnew   = PRF_W'(tag % 64);
      e.pstale = PRF_W'((tag * 7 + 5) % 64);
      e.flush  = fl;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wb(input int p, input int id, input bit fl);
      case (p)
         0: begin wb_valid_0 = 1'b1; wb_id_0 = ID_W'(id); wb_flush_0 = fl; end
         1: begin wb_valid_1 = 1'b1; wb_id_1 = ID_W'(id); wb_flush_1 = fl; end
         default: begin wb_valid_2 = 1'b1; wb_id_2 = ID_W'(id); wb_flush_2 = fl; end
      endcase
   endtask

   task automatic clr_wb();
      wb_valid_0 = 1'b0; wb_valid_1 = 1'b0; wb_valid_2 = 1'b0;
      wb_flush_0 = 1'b0; wb_flush_1 = 1'b0; wb_flush_2 = 1'b0;
   endtask

   // One dispatch cycle: checks ready and ids, queues expected retirements.
   task automatic disp(input bit v0, input bit v1, input exp_t e0, input exp_t e1,
                       input int id0, input int id1, input bit rdy, input bit push);
      disp_valid_0     = v0;
      disp_valid_1     = v1;
      disp_wen_0       = e0.wen;
      disp_ard_0       = e0.ard;
      disp_prd_new_0   = e0.pnew;
      disp_prd_stale_0 = e0.pstale;
      disp_wen_1       = e1.wen;
      disp_ard_1       = e1.ard;
      disp_prd_new_1   = e1.pnew;
      disp_prd_stale_1 = e1.pstale;
      #1;
      check("disp_ready", disp_ready, rdy);
      check("disp_id_0", disp_id_0, id0);
      check("disp_id_1", disp_id_1, id1);
      if (push && rdy) begin
         if (v0) exp_q.push_back(e0);
         if (v1) exp_q.push_back(e1);
      end
      tick();
      disp_valid_0 = 1'b0;
      disp_valid_1 = 1'b0;
   endtask

   // Monitor: in-order scoreboard on the commit ports.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (commit_valid_0) begin
            check("commit0_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("c0_wen", commit_wen_0, e.wen);
               check("c0_ard", commit_ard_0, e.ard);
               check("c0_prd_new", commit_prd_new_0, e.pnew);
               check("c0_prd_stale", commit_prd_stale_0, e.pstale);
               check("c0_recover", recover, e.flush);
            end
         end else begin
            check("c0_idle_zero",
                  {commit_wen_0, commit_ard_0, commit_prd_new_0, commit_prd_stale_0}, 0);
            if (recover) check("recover_has_commit", commit_valid_0, 1);
         end
         if (commit_valid_1) begin
            check("commit1_with_slot0", commit_valid_0, 1);
            check("commit1_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("c1_wen", commit_wen_1, e.wen);
               check("c1_ard", commit_ard_1, e.ard);
               check("c1_prd_new", commit_prd_new_1, e.pnew);
               check("c1_prd_stale", commit_prd_stale_1, e.pstale);
            end
         end else begin
            check("c1_idle_zero",
                  {commit_wen_1, commit_ard_1, commit_prd_new_1, commit_prd_stale_1}, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t a, b, none;
      none = mk(0, 1'b0);

      // 1. Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst_commit_valid_0", commit_valid_0, 0);
      check("rst_commit_valid_1", commit_valid_1, 0);
      check("rst_commit_prd_new_0", commit_prd_new_0, 0);
      check("rst_recover", recover, 0);
      check("rst_disp_ready", disp_ready, 1);
      check("rst_rob_empty", rob_empty, 1);
      rst = 1'b0;

      // 2. Dual dispatch, out-of-order writeback, in-order dual retirement
      a.wen = 1'b1; a.ard = 5'd3; a.pnew = 6'd33; a.pstale = 6'd3; a.flush = 1'b0;
      b.wen = 1'b1; b.ard = 5'd4; b.pnew = 6'd34; b.pstale = 6'd4; b.flush = 1'b0;
      disp(1, 1, a, b, 0, 1, 1, 1);
      check("t2_not_empty", rob_empty, 0);
      set_wb(0, 1, 0);
      tick();
      clr_wb();
      check("t2_no_commit_T1", commit_valid_0, 0);
      set_wb(0, 0, 0);
      tick();
      clr_wb();
      check("t2_no_commit_T2", commit_valid_0, 0);
      tick();
      check("t2_commit_valid_0", commit_valid_0, 1);
      check("t2_commit_valid_1", commit_valid_1, 1);
      tick();
      check("t2_empty_after", rob_empty, 1);

      // 3. Fill to full, reject at 32 and at 31, then drain
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         disp(1, 1, mk(200 + 2 * i, 0), mk(201 + 2 * i, 0), 2 * i, 2 * i + 1, 1, 1);
      end
      disp(1, 1, mk(250, 0), mk(251, 0), 0, 1, 0, 1);
      check("t3_full_tail", disp_id_0, 0);
      set_wb(0, 0, 0);
      tick();
      clr_wb();
      tick();                             // id0 retires here: count = 31
      disp(1, 0, mk(252, 0), none, 0, 1, 0, 1);
      check("t3_31_tail_kept", disp_id_0, 0);
      check("t3_31_ready", disp_ready, 0);
      for (int c = 0; c < 11; c++) begin
         for (int p = 0; p < 3; p++) begin
            if (1 + 3 * c + p <= 31) set_wb(p, 1 + 3 * c + p, 0);
         end
         tick();
         clr_wb();
      end
      repeat (20) tick();
      check("t3_drained", rob_empty, 1);
      check("t3_ready_again", disp_ready, 1);

      // 4. Steady dispatch+commit over 40 instructions, ids wrap 31 -> 0
      for (int k = 0; k < 20; k++) begin
         if (k > 0) begin
            set_wb(0, (2 * k - 2) % 32, 0);
            set_wb(1, (2 * k - 1) % 32, 0);
         end
         disp(1, 1, mk(100 + 2 * k, 0), mk(101 + 2 * k, 0),
              (2 * k) % 32, (2 * k + 1) % 32, 1, 1);
         clr_wb();
      end
      set_wb(0, 6, 0);
      set_wb(1, 7, 0);
      tick();
      clr_wb();
      repeat (4) tick();
      check("t4_drained", rob_empty, 1);
      check("t4_tail", disp_id_0, 8);

      // 5. Flush retirement: only id0 commits, recover pulse, ROB emptied
      rst = 1'b1;
      tick();
      rst = 1'b0;
      disp(1, 1, mk(40, 1), mk(41, 0), 0, 1, 1, 1);
      set_wb(0, 0, 1);
      set_wb(1, 1, 0);
      tick();
      clr_wb();
      disp(1, 1, mk(42, 0), mk(43, 0), 2, 3, 1, 0);   // discarded by the flush
      check("t5_recover", recover, 1);
      check("t5_commit_valid_0", commit_valid_0, 1);
      check("t5_commit_valid_1", commit_valid_1, 0);
      disp(1, 1, mk(44, 0), mk(45, 0), 0, 1, 0, 0);   // recover cycle: rejected
      check("t5_recover_gone", recover, 0);
      check("t5_empty", rob_empty, 1);
      check("t5_no_commit_in_recover", commit_valid_0, 0);
      check("t5_ready", disp_ready, 1);
      check("t5_next_id", disp_id_0, 0);
      check("t5_squashed_left", exp_q.size(), 1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());

      // 6. Slot-1-only dispatch at tail 5; writeback to invalid id ignored
      rst = 1'b1;
      tick();
      rst = 1'b0;
      disp(1, 1, mk(60, 0), mk(61, 0), 0, 1, 1, 1);
      disp(1, 1, mk(62, 0), mk(63, 0), 2, 3, 1, 1);
      disp(1, 0, mk(64, 0), none, 4, 5, 1, 1);
      disp(0, 1, none, mk(65, 0), 5, 5, 1, 1);
      check("t6_tail_6", disp_id_0, 6);
      set_wb(0, 20, 1);
      tick();
      clr_wb();
      tick();
      check("t6_not_empty", rob_empty, 0);
      check("t6_no_recover", recover, 0);
      set_wb(0, 0, 0); set_wb(1, 1, 0); set_wb(2, 2, 0);
      tick();
      set_wb(0, 3, 0); set_wb(1, 4, 0); set_wb(2, 5, 0);
      tick();
      clr_wb();
      repeat (6) tick();
      check("t6_drained", rob_empty, 1);
      check("t6_tail_kept", disp_id_0, 6);

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- 2-wide in-order reorder buffer. Accepts renamed instruction pairs from the rename stage and records writeback completion from the execute ports.
- Retires up to two completed instructions per cycle in program order, producing commit_valid_0/1 plus commit info (wen, ard, prd_new, prd_stale) for the free list and map table.
- Generates recover when a flush-marked instruction retires.

Parameters:
DEPTH, 32, number of entries (power of two, >=4)
ID_W, 5, log2(DEPTH); ROB id width
ARF_W, 5, architectural register index width
PRF_W, 6, physical register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
disp_valid_0  in  1  dispatch slot 0 valid
disp_valid_1  in  1  dispatch slot 1 valid (younger than slot 0)
disp_wen_0/1  in  1 each  instruction writes a destination
disp_ard_0/1  in  ARF_W each  architectural destination
disp_prd_new_0/1  in  PRF_W each  newly allocated physical destination
disp_prd_stale_0/1  in  PRF_W each  previous mapping of ard
disp_ready  out  1  two entries free and no recover in progress
disp_id_0/1  out  ID_W each  ROB id assigned to each slot (combinational from tail)
wb_valid_0..2  in  1 each  writeback port valid
wb_id_0..2  in  ID_W each  ROB id completing
wb_flush_0..2  in  1 each  completing instruction requires pipeline flush at retirement
commit_valid_0/1  out  1 each  retirement slot valid (registered)
commit_wen_0/1  out  1 each
commit_ard_0/1  out  ARF_W each
commit_prd_new_0/1  out  PRF_W each
commit_prd_stale_0/1  out  PRF_W each
recover  out  1  one-cycle flush pulse (registered)
rob_empty  out  1  count == 0

Behaviour:
- State: per-entry {valid, done, flush, wen, ard, prd_new, prd_stale}; head, tail (ID_W, wrap modulo DEPTH); count (ID_W+1 bits).
- Reset: all entries invalid; head = tail = count = 0; every output 0 except disp_ready = 1 and rob_empty = 1.
- disp_ready = (count <= DEPTH-2) && !recover. Dispatch fires only on disp_ready.
- Dispatch, both slots valid: slot 0 → tail, slot 1 → tail+1, tail += 2.
- Dispatch, one slot valid (either slot): that slot → tail, tail += 1. disp_id_0 = tail; disp_id_1 = tail+1 if slot 0 valid, else tail.
- Dispatch with disp_ready low: ignored; no state change.
- Writeback: sets done, and sets flush if wb_flush. Ignored if the target entry is invalid. The done bit is visible to commit the following cycle (no bypass). Multiple ports targeting the same id OR their flush bits.
- Commit slot 0 fires when entry[head] is valid and done.
- Commit slot 1 fires when slot 0 fires, entry[head] has flush = 0, and entry[head+1] is valid and done.
- Committed entries are invalidated and head advances by the commit count.
- At the same edge, commit_* registers load the entry fields. When not committing, commit_valid = 0 and all data fields = 0.
- count_next = count + n_disp - n_commit; simultaneous dispatch and commit are legal.
- Flush: when slot 0 commits an entry with flush = 1, the next edge:
  - registers the commit (slot 1 never fires that cycle);
  - asserts recover for exactly one cycle;
  - invalidates all entries and sets head = tail = count = 0;
  - discards any same-cycle dispatch.
- During the recover cycle: disp_ready = 0 and no commit occurs.
- Full: count == DEPTH-1 or DEPTH → disp_ready = 0, even for single-slot dispatch.
- Empty: commit never fires.
- Reset mid-operation: all state is discarded on the next edge; outputs return to reset values.

Test Plan:
1. Reset asserted 2 cycles → all commit_* = 0, recover = 0, disp_ready = 1, rob_empty = 1.
2. Dual dispatch {wen=1, ard=3, new=33, stale=3} and {wen=1, ard=4, new=34, stale=4} → ids 0 and 1. Then wb id1 at cycle T and wb id0 at T+1 → at T+3, commit_valid_0/1 = 1 with prd_new 33 then 34, in order; nothing commits before.
3. 16 dual dispatches, no writebacks → disp_ready = 1 through count = 30 and 0 at count = 32. A single-slot dispatch attempted at count = 31 is rejected and count stays 31.
4. Steady-state dispatch and commit across 40 instructions → ids wrap from 31 to 0, retirement stays in program order, count never exceeds 32.
5. id0 done with flush = 1 and id1 done → only commit_valid_0 fires (id0); recover pulses 1 cycle; then rob_empty = 1 and the next dispatch receives id 0.
6. Only disp_valid_1 asserted with tail = 5 → disp_id_1 = 5 and tail becomes 6. Writeback to an invalid id 20 → no state change.
